// File: rtl/sad_pkg.sv
// ----------------------------------------------------------------------------
// sad_pkg
// Shared definitions for the SAD4 stage of the motion-estimation SAD pipeline:
// default widths for the partial sums, block SAD, candidate index and window
// counter, plus the tracker state encoding.
// ----------------------------------------------------------------------------
package sad_pkg;

    localparam int IN_W_DEF  = 14;  // width of each partial-sum input
    localparam int SUM_W_DEF = 16;  // width of block SAD, >= IN_W + 2
    localparam int IDX_W_DEF = 16;  // width of candidate index
    localparam int CNT_W_DEF = 16;  // width of per-window candidate counter

    // IDLE: no candidate seen yet in the current window.
    // SEARCH: at least one candidate folded into the running minimum.
    typedef enum logic {
        IDLE   = 1'b0,
        SEARCH = 1'b1
    } track_state_t;

endpackage

// File: rtl/sad4_adder.sv
// ----------------------------------------------------------------------------
// sad4_adder
// Stage A of SAD4: adds the four partial sums into one block SAD and registers
// it together with the candidate sidebands so they stay aligned.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   valid, index,       candidate present / candidate index /
//   trigger             last-of-window flag (qualified by valid)
//   in1..in4            partial sums, IN_W bits each
//   a_valid, a_index,   registered sidebands, one cycle after the inputs
//   a_trigger
//   a_sum               registered block SAD, SUM_W bits
// ----------------------------------------------------------------------------
module sad4_adder
    import sad_pkg::*;
#(
    parameter int IN_W  = IN_W_DEF,
    parameter int SUM_W = SUM_W_DEF,
    parameter int IDX_W = IDX_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             valid,
    input  logic [IDX_W-1:0] index,
    input  logic             trigger,
    input  logic [IN_W-1:0]  in1,
    input  logic [IN_W-1:0]  in2,
    input  logic [IN_W-1:0]  in3,
    input  logic [IN_W-1:0]  in4,
    output logic             a_valid,
    output logic [IDX_W-1:0] a_index,
    output logic             a_trigger,
    output logic [SUM_W-1:0] a_sum
);

    logic [SUM_W-1:0] sum_comb;

    // Each operand is widened before the add so carries out of IN_W are kept;
    // with SUM_W >= IN_W + 2 the four-way sum can never wrap.
    assign sum_comb = SUM_W'(in1) + SUM_W'(in2) + SUM_W'(in3) + SUM_W'(in4);

    // NOTE: state registers use non-blocking assignments so every flop samples
    // its inputs from before the edge, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_valid   <= 1'b0;
            a_index   <= '0;
            a_trigger <= 1'b0;
            a_sum     <= '0;
        end else begin
            a_valid   <= valid;
            a_index   <= index;
            // A trigger without a valid candidate carries no meaning downstream.
            a_trigger <= trigger & valid;
            a_sum     <= sum_comb;
        end
    end

endmodule

// File: rtl/sad4_best_match.sv
// ----------------------------------------------------------------------------
// sad4_best_match
// SAD4 stage: sums the four partial SADs of each candidate and tracks the
// minimum block SAD and its index over a search window. The last candidate of
// a window (SAD4_TriggerBoss) closes it; the result is presented two cycles
// after that candidate with a one-cycle Best_Done pulse.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   SAD4_Valid                 candidate present this cycle
//   SAD4_Index                 candidate index
//   SAD4_TriggerBoss           candidate closes the window (with SAD4_Valid)
//   SAD4_input1..SAD4_input4   partial sums
//   Best_SAD                   minimum SAD of the completed window
//   Best_Index                 index of that minimum (earliest on ties)
//   Best_Count                 candidates in that window, saturating
//   Best_Done                  one-cycle pulse, Best_* valid in that cycle
// ----------------------------------------------------------------------------
module sad4_best_match
    import sad_pkg::*;
#(
    parameter int IN_W  = IN_W_DEF,
    parameter int SUM_W = SUM_W_DEF,
    parameter int IDX_W = IDX_W_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             SAD4_Valid,
    input  logic [IDX_W-1:0] SAD4_Index,
    input  logic             SAD4_TriggerBoss,
    input  logic [IN_W-1:0]  SAD4_input1,
    input  logic [IN_W-1:0]  SAD4_input2,
    input  logic [IN_W-1:0]  SAD4_input3,
    input  logic [IN_W-1:0]  SAD4_input4,
    output logic [SUM_W-1:0] Best_SAD,
    output logic [IDX_W-1:0] Best_Index,
    output logic [CNT_W-1:0] Best_Count,
    output logic             Best_Done
);

    // Stage A outputs
    logic             a_valid;
    logic [IDX_W-1:0] a_index;
    logic             a_trigger;
    logic [SUM_W-1:0] a_sum;

    // Tracker state
    track_state_t     state;
    logic [SUM_W-1:0] min_sad;
    logic [IDX_W-1:0] min_idx;
    logic [CNT_W-1:0] count;

    // Running values with the current stage-A candidate folded in
    logic [SUM_W-1:0] min_sad_next;
    logic [IDX_W-1:0] min_idx_next;
    logic [CNT_W-1:0] count_next;

    sad4_adder #(
        .IN_W  (IN_W),
        .SUM_W (SUM_W),
        .IDX_W (IDX_W)
    ) u_adder (
        .clk       (clk),
        .rst_n     (rst_n),
        .valid     (SAD4_Valid),
        .index     (SAD4_Index),
        .trigger   (SAD4_TriggerBoss),
        .in1       (SAD4_input1),
        .in2       (SAD4_input2),
        .in3       (SAD4_input3),
        .in4       (SAD4_input4),
        .a_valid   (a_valid),
        .a_index   (a_index),
        .a_trigger (a_trigger),
        .a_sum     (a_sum)
    );

    // The candidate is merged combinationally so a trigger candidate joins
    // the comparison in the same cycle it leaves stage A.
    // NOTE: every signal gets a default at the top of always_comb, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        min_sad_next = min_sad;
        min_idx_next = min_idx;
        count_next   = count;
        if (state == IDLE) begin
            min_sad_next = a_sum;
            min_idx_next = a_index;
            count_next   = CNT_W'(1);
        end else begin
            // Strict compare: a tie keeps the earlier index.
            if (a_sum < min_sad) begin
                min_sad_next = a_sum;
                min_idx_next = a_index;
            end
            if (count != {CNT_W{1'b1}}) begin
                count_next = count + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            min_sad    <= '0;
            min_idx    <= '0;
            count      <= '0;
            Best_SAD   <= '0;
            Best_Index <= '0;
            Best_Count <= '0;
            Best_Done  <= 1'b0;
        end else begin
            Best_Done <= 1'b0;
            if (a_valid) begin
                if (a_trigger) begin
                    Best_SAD   <= min_sad_next;
                    Best_Index <= min_idx_next;
                    Best_Count <= count_next;
                    Best_Done  <= 1'b1;
                    // Clear the tracker so the next window starts fresh,
                    // which allows a new candidate in the very next cycle.
                    state      <= IDLE;
                    min_sad    <= '0;
                    min_idx    <= '0;
                    count      <= '0;
                end else begin
                    state      <= SEARCH;
                    min_sad    <= min_sad_next;
                    min_idx    <= min_idx_next;
                    count      <= count_next;
                end
            end
        end
    end

endmodule

// File: tb/tb_sad4_best_match.sv
// ----------------------------------------------------------------------------
// tb_sad4_best_match
// Self-checking bench for sad4_best_match: directed windows with hand-computed
// results plus a long randomised run checked against a behavioural model.
// ----------------------------------------------------------------------------
module tb_sad4_best_match;

    localparam int IN_W  = 14;
    localparam int SUM_W = 16;
    localparam int IDX_W = 16;
    localparam int CNT_W = 16;

    logic             clk;
    logic             rst_n;
    logic             valid;
    logic [IDX_W-1:0] index;
    logic             trig;
    logic [IN_W-1:0]  in1, in2, in3, in4;
    logic [SUM_W-1:0] best_sad;
    logic [IDX_W-1:0] best_index;
    logic [CNT_W-1:0] best_count;
    logic             best_done;

    int total;
    int bad;

    typedef struct {
        logic [SUM_W-1:0] sad;
        logic [IDX_W-1:0] idx;
        logic [CNT_W-1:0] cnt;
    } result_t;

    result_t exp_q[$];
    bit      mon_en;

    sad4_best_match #(
        .IN_W  (IN_W),
        .SUM_W (SUM_W),
        .IDX_W (IDX_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .SAD4_Valid       (valid),
        .SAD4_Index       (index),
        .SAD4_TriggerBoss (trig),
        .SAD4_input1      (in1),
        .SAD4_input2      (in2),
        .SAD4_input3      (in3),
        .SAD4_input4      (in4),
        .Best_SAD         (best_sad),
        .Best_Index       (best_index),
        .Best_Count       (best_count),
        .Best_Done        (best_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present one cycle of inputs, then move to 1 time unit after the edge
    // that captured them.
    task automatic drive(input logic v, input logic [IDX_W-1:0] idx, input logic t,
                         input logic [IN_W-1:0] a, input logic [IN_W-1:0] b,
                         input logic [IN_W-1:0] c, input logic [IN_W-1:0] d);
        valid = v;
        index = idx;
        trig  = t;
        in1   = a;
        in2   = b;
        in3   = c;
        in4   = d;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        drive(1'b0, '0, 1'b0, '0, '0, '0, '0);
    endtask

    // Scoreboard for the randomised run: every Done must match the oldest
    // window the model closed.
    always @(negedge clk) begin
        if (mon_en && best_done) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL rand_unexpected_done: got sad=%0d idx=%0d cnt=%0d, required no Done",
                         best_sad, best_index, best_count);
            end else begin
                result_t e;
                e = exp_q.pop_front();
                if (best_sad !== e.sad || best_index !== e.idx || best_count !== e.cnt) begin
                    bad++;
                    $display("FAIL rand_window: got sad=%0d idx=%0d cnt=%0d, required sad=%0d idx=%0d cnt=%0d",
                             best_sad, best_index, best_count, e.sad, e.idx, e.cnt);
                end
            end
        end
    end

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, IDX_W'($urandom), 1'b1, IN_W'($urandom), IN_W'($urandom),
                  IN_W'($urandom), IN_W'($urandom));
            total++;
            if (best_sad !== 0 || best_index !== 0 || best_count !== 0 || best_done !== 1'b0) begin
                bad++;
                $display("FAIL reset_hold: got sad=%0d idx=%0d cnt=%0d done=%0b, required all 0",
                         best_sad, best_index, best_count, best_done);
            end
        end
        idle();
        rst_n = 1'b1;
        idle();

        // Complete one window so the outputs hold a nonzero result.
        drive(1'b1, 16'h0077, 1'b1, 14'd10, 14'd20, 14'd30, 14'd40);
        idle();
        total++;
        if (best_done !== 1'b1 || best_sad !== 16'd100 || best_index !== 16'h0077) begin
            bad++;
            $display("FAIL reset_prewindow: got done=%0b sad=%0d idx=%0h, required done=1 sad=100 idx=77",
                     best_done, best_sad, best_index);
        end

        // Open a window, close it, and reset while the trigger is in flight.
        drive(1'b1, 16'd1, 1'b0, 14'd5, 14'd5, 14'd5, 14'd5);
        drive(1'b1, 16'd2, 1'b1, 14'd1, 14'd1, 14'd1, 14'd1);
        valid = 1'b0;
        trig  = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if (best_sad !== 0 || best_index !== 0 || best_count !== 0 || best_done !== 1'b0) begin
            bad++;
            $display("FAIL reset_async: got sad=%0d idx=%0d cnt=%0d done=%0b, required all 0",
                     best_sad, best_index, best_count, best_done);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            idle();
            total++;
            if (best_done !== 1'b0) begin
                bad++;
                $display("FAIL reset_discard: got done=%0b in cycle %0d, required 0", best_done, i);
            end
        end
    endtask

    task automatic test_single_window();
        drive(1'b1, 16'd0, 1'b0, 14'd900, 14'd0, 14'd0, 14'd0);
        drive(1'b1, 16'd1, 1'b0, 14'd100, 14'd100, 14'd100, 14'd100);
        drive(1'b1, 16'd2, 1'b0, 14'd700, 14'd0, 14'd0, 14'd0);
        drive(1'b1, 16'd3, 1'b1, 14'd0, 14'd400, 14'd0, 14'd0);
        total++;
        if (best_done !== 1'b0) begin
            bad++;
            $display("FAIL single_early: got done=%0b one cycle after trigger, required 0", best_done);
        end
        idle();
        total++;
        if (best_done !== 1'b1 || best_sad !== 16'd400 || best_index !== 16'd1 || best_count !== 16'd4) begin
            bad++;
            $display("FAIL single_window: got done=%0b sad=%0d idx=%0d cnt=%0d, required done=1 sad=400 idx=1 cnt=4",
                     best_done, best_sad, best_index, best_count);
        end
        idle();
        total++;
        if (best_done !== 1'b0 || best_sad !== 16'd400 || best_index !== 16'd1 || best_count !== 16'd4) begin
            bad++;
            $display("FAIL single_hold: got done=%0b sad=%0d idx=%0d cnt=%0d, required done=0 sad=400 idx=1 cnt=4",
                     best_done, best_sad, best_index, best_count);
        end
    endtask

    task automatic test_max_sum();
        drive(1'b1, 16'hAAAA, 1'b1, 14'd16383, 14'd16383, 14'd16383, 14'd16383);
        drive(1'b1, 16'h5555, 1'b1, 14'd0, 14'd0, 14'd0, 14'd0);
        total++;
        if (best_done !== 1'b1 || best_sad !== 16'd65532 || best_index !== 16'hAAAA || best_count !== 16'd1) begin
            bad++;
            $display("FAIL max_sum: got done=%0b sad=%0d idx=%0h cnt=%0d, required done=1 sad=65532 idx=aaaa cnt=1",
                     best_done, best_sad, best_index, best_count);
        end
        idle();
        total++;
        if (best_done !== 1'b1 || best_sad !== 16'd0 || best_index !== 16'h5555) begin
            bad++;
            $display("FAIL zero_sum: got done=%0b sad=%0d idx=%0h, required done=1 sad=0 idx=5555",
                     best_done, best_sad, best_index);
        end
        idle();
    endtask

    task automatic test_single_candidate();
        drive(1'b1, 16'h1234, 1'b1, 14'd20, 14'd10, 14'd15, 14'd5);
        idle();
        total++;
        if (best_done !== 1'b1 || best_sad !== 16'd50 || best_index !== 16'h1234 || best_count !== 16'd1) begin
            bad++;
            $display("FAIL single_candidate: got done=%0b sad=%0d idx=%0h cnt=%0d, required done=1 sad=50 idx=1234 cnt=1",
                     best_done, best_sad, best_index, best_count);
        end
        idle();
    endtask

    task automatic test_back_to_back();
        drive(1'b1, 16'd10, 1'b0, 14'd5, 14'd0, 14'd0, 14'd0);
        idle();
        drive(1'b0, 16'd99, 1'b0, 14'd1, 14'd0, 14'd0, 14'd0);  // bubble with junk data
        drive(1'b1, 16'd11, 1'b1, 14'd1, 14'd1, 14'd1, 14'd0);
        drive(1'b1, 16'd20, 1'b1, 14'd2, 14'd2, 14'd2, 14'd2);
        total++;
        if (best_done !== 1'b1 || best_sad !== 16'd3 || best_index !== 16'd11 || best_count !== 16'd2) begin
            bad++;
            $display("FAIL b2b_w1: got done=%0b sad=%0d idx=%0d cnt=%0d, required done=1 sad=3 idx=11 cnt=2",
                     best_done, best_sad, best_index, best_count);
        end
        idle();
        total++;
        if (best_done !== 1'b1 || best_sad !== 16'd8 || best_index !== 16'd20 || best_count !== 16'd1) begin
            bad++;
            $display("FAIL b2b_w2: got done=%0b sad=%0d idx=%0d cnt=%0d, required done=1 sad=8 idx=20 cnt=1",
                     best_done, best_sad, best_index, best_count);
        end
        // Triggers without Valid must never close a window.
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 16'd30, 1'b1, 14'd7, 14'd7, 14'd7, 14'd7);
        end
        for (int i = 0; i < 3; i++) begin
            total++;
            if (best_done !== 1'b0) begin
                bad++;
                $display("FAIL trig_no_valid: got done=%0b at step %0d, required 0", best_done, i);
            end
            idle();
        end
    endtask

    task automatic test_random();
        int               n;
        int               len;
        logic [IN_W-1:0]  a, b, c, d;
        logic [IDX_W-1:0] idx;
        logic [SUM_W-1:0] s;
        result_t          cur;

        n      = 0;
        mon_en = 1'b1;
        cur    = '{sad: '0, idx: '0, cnt: '0};
        while (n < 10000) begin
            len = $urandom_range(1, 300);
            for (int k = 0; k < len; k++) begin
                if ($urandom_range(0, 4) == 0) begin
                    drive(1'b0, IDX_W'($urandom), 1'($urandom), IN_W'($urandom), IN_W'($urandom),
                          IN_W'($urandom), IN_W'($urandom));
                end
                a   = IN_W'($urandom);
                b   = IN_W'($urandom);
                c   = IN_W'($urandom);
                d   = IN_W'($urandom);
                idx = IDX_W'($urandom);
                s   = SUM_W'(int'(a) + int'(b) + int'(c) + int'(d));
                if (k == 0) begin
                    cur = '{sad: s, idx: idx, cnt: 1};
                end else begin
                    if (s < cur.sad) begin
                        cur.sad = s;
                        cur.idx = idx;
                    end
                    cur.cnt = cur.cnt + 1'b1;
                end
                if (k == len - 1) exp_q.push_back(cur);
                drive(1'b1, idx, (k == len - 1), a, b, c, d);
                n++;
            end
        end
        for (int i = 0; i < 4; i++) idle();
        mon_en = 1'b0;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL rand_missing_done: got %0d windows without Done, required 0", exp_q.size());
        end
    endtask

    initial begin
        total  = 0;
        bad    = 0;
        mon_en = 1'b0;
        valid  = 1'b0;
        index  = '0;
        trig   = 1'b0;
        in1    = '0;
        in2    = '0;
        in3    = '0;
        in4    = '0;
        rst_n  = 1'b0;
        #1;
        test_reset();
        test_single_window();
        test_max_sum();
        test_single_candidate();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
